// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and width helpers for the FIFO family.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width for a power-of-two depth (at least one bit).
  function automatic int fifo_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM, synchronous write, registered read with
// read enable. No reset anywhere so the array and read register map to BRAM.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Read-before-write: a same-address read returns the old word, which the
  // full-FIFO simultaneous read/write case relies on.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_fwft_stat.sv
// fifo_fwft_stat: single-clock FIFO with selectable standard / first-word-
// fall-through read, fill count, almost flags, flush and sticky error flags.
module fifo_fwft_stat
  import fifo_pkg::*;
#(
  parameter int         WIDTH = 8,
  parameter int         DEPTH = 16,
  parameter fifo_mode_e MODE  = FIFO_STD,
  parameter int         CW    = fifo_cw(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             wr_dv_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [CW-1:0]    AF_level_i,
  output logic             AF_flag_o,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic             rd_dv_o,
  output logic [WIDTH-1:0] rd_data_o,
  input  logic [CW-1:0]    AE_level_i,
  output logic             AE_flag_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic             ovf_o,
  output logic             udf_o,
  input  logic             clr_err_i
);

  localparam int            AW       = fifo_aw(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rd_dv_q, rd_dv_d;
  // Set once the RAM read register holds real data; until then the
  // (unreset) BRAM output is masked so rd_data_o reads 0 after reset.
  logic             seen_q, seen_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             empty, full;
  logic             rd_acc, wr_acc, ram_re, fetch;
  logic             ovf_set, udf_set;
  logic [WIDTH-1:0] ram_rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Accept/refuse decisions; flush overrides both sides.
  // In FWFT the RAM read register is the presented head word: it is loaded
  // (fetch) only while nothing is presented, so a pop is followed by one
  // idle cycle before the next word appears.
  always_comb begin
    rd_acc = 1'b0;
    fetch  = 1'b0;
    ram_re = 1'b0;
    if (MODE == FIFO_FWFT) begin
      rd_acc = rd_en_i & rd_dv_q & ~flush_i;
      fetch  = ~rd_dv_q & ~empty & ~flush_i;
      ram_re = fetch;
    end else begin
      rd_acc = rd_en_i & ~empty & ~flush_i;
      ram_re = rd_acc;
    end
    wr_acc  = wr_dv_i & (~full | rd_acc) & ~flush_i;
    ovf_set = wr_dv_i & ~wr_acc & ~flush_i;
    udf_set = rd_en_i & ~rd_acc & ~flush_i;
  end

  // Pointer, occupancy and read-valid next state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rd_dv_d = rd_dv_q;
    seen_d  = seen_q | ram_re;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      rd_dv_d = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + AW'(1);
      if (ram_re) rptr_d = rptr_q + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (MODE == FIFO_FWFT) rd_dv_d = fetch | (rd_dv_q & ~rd_acc);
      else                   rd_dv_d = rd_acc;
    end
  end

  // Sticky error flags: a new error in the clearing cycle keeps the flag set.
  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~clr_err_i);
    udf_d = udf_set | (udf_q & ~clr_err_i);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rd_dv_q <= 1'b0;
      seen_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rd_dv_q <= rd_dv_d;
      seen_q  <= seen_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (wr_data_i),
    .re_i    (ram_re),
    .raddr_i (rptr_q),
    .rdata_o (ram_rdata)
  );

  assign count_o   = count_q;
  assign empty_o   = empty;
  assign full_o    = full;
  assign rd_dv_o   = rd_dv_q;
  assign rd_data_o = seen_q ? ram_rdata : '0;
  assign ovf_o     = ovf_q;
  assign udf_o     = udf_q;
  assign AE_flag_o = (count_q <= AE_level_i);
  assign AF_flag_o = (count_q >= AF_level_i);

endmodule

// File: tb/tb_fifo_fwft_stat.sv
// Bench for fifo_fwft_stat: one STD instance (DEPTH=4) and one FWFT instance
// (DEPTH=8) on a shared clock/reset, with queue scoreboards per instance.
module tb_fifo_fwft_stat;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // STD instance
  logic       s_flush, s_wr, s_rd, s_clr;
  logic [7:0] s_wdata, s_rdata;
  logic [2:0] s_ae_lvl, s_af_lvl, s_cnt;
  logic       s_af, s_full, s_dv, s_ae, s_empty, s_ovf, s_udf;
  // FWFT instance
  logic       f_flush, f_wr, f_rd, f_clr;
  logic [7:0] f_wdata, f_rdata;
  logic [3:0] f_ae_lvl, f_af_lvl, f_cnt;
  logic       f_af, f_full, f_dv, f_ae, f_empty, f_ovf, f_udf;

  int total = 0;
  int bad   = 0;
  logic [7:0] s_q[$];
  logic [7:0] f_q[$];

  fifo_fwft_stat #(.WIDTH(8), .DEPTH(4), .MODE(FIFO_STD)) u_std (
    .clk_i(clk), .rstn_i(rstn), .flush_i(s_flush), .wr_dv_i(s_wr), .wr_data_i(s_wdata),
    .AF_level_i(s_af_lvl), .AF_flag_o(s_af), .full_o(s_full), .rd_en_i(s_rd),
    .rd_dv_o(s_dv), .rd_data_o(s_rdata), .AE_level_i(s_ae_lvl), .AE_flag_o(s_ae),
    .empty_o(s_empty), .count_o(s_cnt), .ovf_o(s_ovf), .udf_o(s_udf), .clr_err_i(s_clr));

  fifo_fwft_stat #(.WIDTH(8), .DEPTH(8), .MODE(FIFO_FWFT)) u_fwft (
    .clk_i(clk), .rstn_i(rstn), .flush_i(f_flush), .wr_dv_i(f_wr), .wr_data_i(f_wdata),
    .AF_level_i(f_af_lvl), .AF_flag_o(f_af), .full_o(f_full), .rd_en_i(f_rd),
    .rd_dv_o(f_dv), .rd_data_o(f_rdata), .AE_level_i(f_ae_lvl), .AE_flag_o(f_ae),
    .empty_o(f_empty), .count_o(f_cnt), .ovf_o(f_ovf), .udf_o(f_udf), .clr_err_i(f_clr));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    // {cnt, empty, full, dv, ovf, udf, ae, af, data}
    total++;
    if ({s_cnt, s_empty, s_full, s_dv, s_ovf, s_udf, s_ae, s_af, s_rdata} !==
        {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      bad++; $display("FAIL reset_std act=%h exp=%h",
        {s_cnt, s_empty, s_full, s_dv, s_ovf, s_udf, s_ae, s_af, s_rdata},
        {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    end
    total++;
    if ({f_cnt, f_empty, f_full, f_dv, f_ovf, f_udf, f_ae, f_af, f_rdata} !==
        {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      bad++; $display("FAIL reset_fwft act=%h exp=%h",
        {f_cnt, f_empty, f_full, f_dv, f_ovf, f_udf, f_ae, f_af, f_rdata},
        {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    end
    rstn = 1'b1;
  endtask

  // Read one word from the STD instance and check the one-cycle dv pulse.
  task automatic std_read(input string nm);
    logic [7:0] exp;
    s_rd = 1'b1; tick(); s_rd = 1'b0;
    exp = s_q.pop_front();
    total++;
    if ({s_dv, s_rdata} !== {1'b1, exp}) begin
      bad++; $display("FAIL %s_data act=%b/%h exp=1/%h", nm, s_dv, s_rdata, exp);
    end
    tick();
    total++;
    if (s_dv !== 1'b0) begin bad++; $display("FAIL %s_dv_drop act=%b exp=0", nm, s_dv); end
  endtask

  task automatic test_std_fill_read();
    for (int i = 0; i < 4; i++) begin
      s_wr = 1'b1; s_wdata = 8'(8'hBB + i);
      tick(); s_wr = 1'b0; s_q.push_back(8'(8'hBB + i));
      total++;
      if (s_cnt !== 3'(i + 1)) begin bad++; $display("FAIL fill_cnt act=%0d exp=%0d", s_cnt, i + 1); end
      tick();
    end
    total++;
    if ({s_full, s_cnt} !== {1'b1, 3'd4}) begin
      bad++; $display("FAIL fill_full act=%b/%0d exp=1/4", s_full, s_cnt);
    end
    for (int i = 0; i < 4; i++) std_read("std_rd");
    total++;
    if ({s_empty, s_cnt} !== {1'b1, 3'd0}) begin
      bad++; $display("FAIL drain_empty act=%b/%0d exp=1/0", s_empty, s_cnt);
    end
  endtask

  task automatic test_std_errors();
    for (int i = 0; i < 4; i++) begin
      s_wr = 1'b1; s_wdata = 8'(8'hC0 + i); tick(); s_q.push_back(8'(8'hC0 + i));
    end
    s_wdata = 8'hAA; tick(); s_wr = 1'b0;
    total++;
    if ({s_ovf, s_full, s_cnt} !== {1'b1, 1'b1, 3'd4}) begin
      bad++; $display("FAIL ovf_set act=%b%b/%0d exp=11/4", s_ovf, s_full, s_cnt);
    end
    for (int i = 0; i < 4; i++) std_read("ovf_rd");
    s_rd = 1'b1; tick(); s_rd = 1'b0;
    total++;
    if ({s_udf, s_dv} !== 2'b10) begin bad++; $display("FAIL udf_set act=%b%b exp=10", s_udf, s_dv); end
    // clear with a same-cycle refused read: udf stays, ovf clears
    s_clr = 1'b1; s_rd = 1'b1; tick(); s_rd = 1'b0;
    total++;
    if ({s_ovf, s_udf} !== 2'b01) begin bad++; $display("FAIL clr_vs_new act=%b%b exp=01", s_ovf, s_udf); end
    tick(); s_clr = 1'b0;
    total++;
    if ({s_ovf, s_udf} !== 2'b00) begin bad++; $display("FAIL clr_err act=%b%b exp=00", s_ovf, s_udf); end
    // empty + simultaneous read/write: write lands, read refused
    s_wr = 1'b1; s_rd = 1'b1; s_wdata = 8'h77; tick();
    s_wr = 1'b0; s_rd = 1'b0; s_q.push_back(8'h77);
    total++;
    if ({s_cnt, s_udf, s_dv} !== {3'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL empty_rw act=%0d/%b%b exp=1/10", s_cnt, s_udf, s_dv);
    end
    std_read("empty_rw_rd");
    s_clr = 1'b1; tick(); s_clr = 1'b0;
  endtask

  task automatic test_std_simul_full();
    for (int i = 0; i < 4; i++) begin
      s_wr = 1'b1; s_wdata = 8'(8'h10 + i); tick(); s_q.push_back(8'(8'h10 + i));
    end
    s_rd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] exp;
      s_wdata = 8'(8'h20 + i); s_q.push_back(8'(8'h20 + i));
      tick();
      exp = s_q.pop_front();
      total++;
      if ({s_full, s_cnt, s_dv, s_rdata} !== {1'b1, 3'd4, 1'b1, exp}) begin
        bad++; $display("FAIL simul_full act=%b/%0d/%b/%h exp=1/4/1/%h", s_full, s_cnt, s_dv, s_rdata, exp);
      end
    end
    s_wr = 1'b0; s_rd = 1'b0; tick();
    for (int i = 0; i < 4; i++) std_read("simul_drain");
    total++;
    if ({s_empty, s_ovf, s_udf} !== 3'b100) begin
      bad++; $display("FAIL simul_end act=%b exp=100", {s_empty, s_ovf, s_udf});
    end
  endtask

  task automatic test_std_flags();
    logic [4:0] exp_ae, exp_af;
    exp_ae = 5'b00011;  // bit k: expected AE at count k (level 1)
    exp_af = 5'b11000;  // bit k: expected AF at count k (level 3)
    rstn = 1'b0; #2; rstn = 1'b1;
    s_q.delete();
    s_ae_lvl = 3'd1; s_af_lvl = 3'd3;
    s_wr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({s_ae, s_af, s_cnt} !== {exp_ae[k], exp_af[k], 3'(k)}) begin
        bad++; $display("FAIL flags_k%0d act=%b%b/%0d exp=%b%b/%0d", k, s_ae, s_af, s_cnt, exp_ae[k], exp_af[k], k);
      end
      s_wdata = 8'(8'h40 + k);
      if (k < 4) s_q.push_back(8'(8'h40 + k));
      tick();
    end
    s_wr = 1'b0;
    total++;
    if ({s_full, s_cnt, s_ovf, s_af} !== {1'b1, 3'd4, 1'b1, 1'b1}) begin
      bad++; $display("FAIL flags_full act=%b/%0d/%b%b exp=1/4/11", s_full, s_cnt, s_ovf, s_af);
    end
    s_af_lvl = 3'd4; s_ae_lvl = 3'd0; #1;
    total++;
    if ({s_af, s_ae} !== 2'b10) begin bad++; $display("FAIL lvl_edge_full act=%b%b exp=10", s_af, s_ae); end
    for (int j = 0; j < 4; j++) begin
      std_read("flags_rd");
      total++;
      if ({s_af, s_ae} !== {1'b0, (j == 3)}) begin
        bad++; $display("FAIL lvl_edge_j%0d act=%b%b exp=0%b", j, s_af, s_ae, (j == 3));
      end
    end
    s_clr = 1'b1; tick(); s_clr = 1'b0;
    s_ae_lvl = 3'd1; s_af_lvl = 3'd3;
  endtask

  // Bounded wait for the FWFT head word.
  task automatic fwft_wait(input string nm);
    int w = 0;
    while (f_dv !== 1'b1 && w < 6) begin tick(); w++; end
    total++;
    if (f_dv !== 1'b1) begin bad++; $display("FAIL %s_timeout act=%b exp=1", nm, f_dv); end
  endtask

  task automatic test_fwft_single();
    logic [7:0] exp;
    f_wr = 1'b1; f_wdata = 8'h5A; tick(); f_wr = 1'b0; f_q.push_back(8'h5A);
    total++;
    if ({f_dv, f_cnt, f_empty} !== {1'b0, 4'd1, 1'b0}) begin
      bad++; $display("FAIL fwft_n act=%b/%0d/%b exp=0/1/0", f_dv, f_cnt, f_empty);
    end
    tick();
    exp = f_q.pop_front();
    total++;
    if ({f_dv, f_rdata} !== {1'b1, exp}) begin
      bad++; $display("FAIL fwft_present act=%b/%h exp=1/%h", f_dv, f_rdata, exp);
    end
    tick();
    total++;
    if ({f_dv, f_rdata} !== {1'b1, exp}) begin
      bad++; $display("FAIL fwft_hold act=%b/%h exp=1/%h", f_dv, f_rdata, exp);
    end
    f_rd = 1'b1; tick(); f_rd = 1'b0;
    total++;
    if ({f_dv, f_empty, f_cnt, f_udf} !== {1'b0, 1'b1, 4'd0, 1'b0}) begin
      bad++; $display("FAIL fwft_pop act=%b%b/%0d/%b exp=01/0/0", f_dv, f_empty, f_cnt, f_udf);
    end
  endtask

  task automatic test_fwft_back_to_back();
    for (int i = 0; i < 4; i++) begin
      f_wr = 1'b1; f_wdata = 8'(8'h60 + i); tick(); f_q.push_back(8'(8'h60 + i));
    end
    f_wr = 1'b0;
    total++;
    if ({f_cnt, f_dv} !== {4'd4, 1'b1}) begin
      bad++; $display("FAIL fwft_cnt4 act=%0d/%b exp=4/1", f_cnt, f_dv);
    end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp;
      fwft_wait("b2b");
      exp = f_q.pop_front();
      total++;
      if (f_rdata !== exp) begin bad++; $display("FAIL b2b_data act=%h exp=%h", f_rdata, exp); end
      f_rd = 1'b1; tick(); f_rd = 1'b0;
      total++;
      if (f_dv !== 1'b0) begin bad++; $display("FAIL b2b_gap act=%b exp=0", f_dv); end
    end
    // pop request while nothing is presented is refused
    f_wr = 1'b1; f_wdata = 8'h7E; tick(); f_wr = 1'b0; f_q.push_back(8'h7E);
    f_rd = 1'b1; tick(); f_rd = 1'b0;
    total++;
    if ({f_udf, f_dv, f_cnt} !== {1'b1, 1'b1, 4'd1}) begin
      bad++; $display("FAIL fwft_udf act=%b%b/%0d exp=11/1", f_udf, f_dv, f_cnt);
    end
    total++;
    if (f_rdata !== f_q[0]) begin bad++; $display("FAIL fwft_udf_data act=%h exp=%h", f_rdata, f_q[0]); end
    void'(f_q.pop_front());
    f_rd = 1'b1; tick(); f_rd = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      f_wr = 1'b1; f_wdata = 8'(8'h30 + i); tick();
    end
    f_wr = 1'b0;
    fwft_wait("flush_pre");
    total++;
    if (f_cnt !== 4'd3) begin bad++; $display("FAIL flush_pre_cnt act=%0d exp=3", f_cnt); end
    f_flush = 1'b1; f_wr = 1'b1; f_rd = 1'b1; f_wdata = 8'h99;
    tick();
    f_flush = 1'b0; f_wr = 1'b0; f_rd = 1'b0;
    f_q.delete();
    total++;
    if ({f_cnt, f_empty, f_dv, f_udf, f_ovf} !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL flush act=%0d/%b%b/%b%b exp=0/10/10", f_cnt, f_empty, f_dv, f_udf, f_ovf);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({f_dv, f_cnt} !== {1'b0, 4'd0}) begin
        bad++; $display("FAIL flush_quiet act=%b/%0d exp=0/0", f_dv, f_cnt);
      end
    end
    // STD side: flush beats a same-cycle read
    s_wr = 1'b1; s_wdata = 8'h51; tick(); s_wdata = 8'h52; tick(); s_wr = 1'b0;
    s_flush = 1'b1; s_rd = 1'b1; tick(); s_flush = 1'b0; s_rd = 1'b0;
    total++;
    if ({s_cnt, s_empty, s_dv, s_udf} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL std_flush act=%0d/%b%b%b exp=0/100", s_cnt, s_empty, s_dv, s_udf);
    end
    f_clr = 1'b1; tick(); f_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    s_wr = 1'b1; f_wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_wdata = 8'(8'hE0 + i); f_wdata = 8'(8'hE0 + i); tick();
    end
    #2 rstn = 1'b0; #1;
    total++;
    if ({s_cnt, s_empty, s_full, s_dv, s_ovf, s_udf, s_rdata} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++; $display("FAIL midrst_std act=%h exp=%h", {s_cnt, s_empty, s_full, s_dv, s_ovf, s_udf, s_rdata},
        {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    total++;
    if ({f_cnt, f_empty, f_full, f_dv, f_ovf, f_udf, f_rdata} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++; $display("FAIL midrst_fwft act=%h exp=%h", {f_cnt, f_empty, f_full, f_dv, f_ovf, f_udf, f_rdata},
        {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    s_wr = 1'b0; f_wr = 1'b0;
    tick(); rstn = 1'b1;
    f_q.delete();
    f_wr = 1'b1; f_wdata = 8'hF0; tick(); f_wr = 1'b0; f_q.push_back(8'hF0);
    fwft_wait("post_rst");
    exp = f_q.pop_front();
    total++;
    if (f_rdata !== exp) begin bad++; $display("FAIL post_rst_data act=%h exp=%h", f_rdata, exp); end
  endtask

  initial begin
    rstn = 1'b0;
    {s_flush, s_wr, s_rd, s_clr} = '0; s_wdata = '0;
    {f_flush, f_wr, f_rd, f_clr} = '0; f_wdata = '0;
    s_ae_lvl = 3'd1; s_af_lvl = 3'd3;
    f_ae_lvl = 4'd2; f_af_lvl = 4'd6;
    test_reset();
    test_std_fill_read();
    test_std_errors();
    test_std_simul_full();
    test_std_flags();
    test_fwft_single();
    test_fwft_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
